// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, buffer depth,
// header field positions and the packet length counter width.
package router_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 16;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_ADDR_MSB  = 1;
    localparam int HDR_LEN_LSB   = 2;
    localparam int HDR_LEN_MSB   = 7;

    // Wide enough for the maximum payload length (63) plus the parity byte
    localparam int PKT_CNT_WIDTH = 7;

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router. Stores bytes from the
// register stage together with a header flag, returns them with a registered
// read port, and tracks the bytes still owed for the packet being read so a
// timed-out packet can be flushed by soft_reset.
module router_fifo #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int DEPTH      = router_pkg::FIFO_DEPTH,
    parameter int PTR_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  pkt_active,
    output logic                  full,
    output logic                  empty
);

    import router_pkg::*;

    localparam int IDX_WIDTH = PTR_WIDTH - 1;

    // Pointers carry one extra wrap bit above the array index so that
    // full and empty can be told apart when the indices match.
    logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;

    // Entry bit 8 (header flag) is kept apart from the data bits so that only
    // the flags need clearing on a flush; stale data behind a cleared flag is
    // never read because the pointers are cleared together with it.
    logic [DATA_WIDTH-1:0]    dat_q [DEPTH];
    logic [DEPTH-1:0]         hdr_q;

    logic [IDX_WIDTH-1:0]     wr_idx;
    logic [IDX_WIDTH-1:0]     rd_idx;
    logic                     flush;
    logic                     wr_ok;
    logic                     rd_ok;
    logic                     rd_hdr;
    logic [DATA_WIDTH-1:0]    rd_dat;

    assign wr_idx = wr_ptr_q[IDX_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[IDX_WIDTH-1:0];

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]) &&
                    (wr_ptr_q[IDX_WIDTH-1:0] == rd_ptr_q[IDX_WIDTH-1:0]);

    // Both resets act identically; any transfer in a flush cycle is discarded.
    assign flush  = reset || soft_reset;

    // Flags are the pre-edge values, so a write while full is dropped even
    // when a read frees a slot on the same edge.
    assign wr_ok  = write_enb && !full;
    assign rd_ok  = read_enb && !empty;

    assign rd_hdr = hdr_q[rd_idx];
    assign rd_dat = dat_q[rd_idx];

    assign data_out   = data_out_q;
    assign pkt_active = (pkt_cnt_q != '0);

    // Next-state for pointers, read data register and packet length counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end

        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_WIDTH'(1);
            data_out_d = rd_dat;
            // A header reloads the count with payload length plus the parity
            // byte; every other byte counts down until the packet is drained.
            if (rd_hdr) begin
                pkt_cnt_d = PKT_CNT_WIDTH'(rd_dat[HDR_LEN_MSB:HDR_LEN_LSB]) +
                            PKT_CNT_WIDTH'(1);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - PKT_CNT_WIDTH'(1);
            end
        end
    end

    // Control and read-data registers, cleared by either reset.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Header flag per entry, cleared on flush and written with each byte.
    always_ff @(posedge clock) begin
        if (flush) begin
            hdr_q <= '0;
        end else if (wr_ok) begin
            hdr_q[wr_idx] <= lfd_state;
        end
    end

    // Data storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (!flush && wr_ok) begin
            dat_q[wr_idx] <= data_in;
        end
    end

endmodule
